// File: rtl/tcp_server.sv
// tcp_server
//   Passive-open (responder) TCP connection controller on the 224-bit packet
//   bus. It listens on LOCAL_PORT and answers a SYN with SYN+ACK. It
//   completes the three-way handshake and acknowledges in-order data words.
//   It also runs the passive close: ACK, then FIN+ACK, then a wait for the
//   final ACK.
//
//   Packet layout (both directions):
//     [15:0] dest port, [31:16] src port, [63:32] seq, [95:64] ack num,
//     [111:96] window, 112 FIN, 113 SYN, 114 RST, 115 PSH, 116 ACK, 117 URG,
//     [123:118] reserved, [127:124] header len, [143:128] urgent ptr,
//     [159:144] checksum, [191:160] options, [223:192] data
//
//   Ports:
//     clk           clock
//     rst           synchronous active-high reset
//     in_valid      packet_in carries a received segment this cycle
//     packet_in     received segment
//     out_valid     one-cycle pulse, packet_out holds a transmitted segment
//     packet_out    transmitted segment
//     rx_data       payload of the last accepted in-order segment
//     rx_data_valid one-cycle pulse accompanying rx_data
//     conn_open     high while the connection is ESTABLISHED
module tcp_server #(
    parameter logic [15:0] LOCAL_PORT = 16'd80,
    parameter logic [31:0] ISN        = 32'h0000_1000,
    parameter logic [15:0] WINDOW     = 16'd1024,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [223:0] packet_in,
    output logic         out_valid,
    output logic [223:0] packet_out,
    output logic [31:0]  rx_data,
    output logic         rx_data_valid,
    output logic         conn_open
);

    typedef enum logic [2:0] {
        LISTEN,
        SYN_RCVD,
        ESTABLISHED,
        CLOSE_WAIT,
        LAST_ACK
    } state_t;

    state_t        state, state_n;
    logic [15:0]   remote_port, remote_port_n;
    logic [31:0]   rcv_nxt, rcv_nxt_n;
    logic [31:0]   snd_nxt, snd_nxt_n;
    logic [15:0]   timer, timer_n;
    logic          out_valid_n;
    logic [223:0]  packet_out_n;
    logic [31:0]   rx_data_n;
    logic          rx_data_valid_n;

    // Received segment fields
    logic [15:0] in_dest, in_src;
    logic [31:0] in_seq, in_ack, in_data;
    logic        in_fin, in_syn, in_rst, in_psh, in_ackf;
    logic        unused_bits;

    assign in_dest = packet_in[15:0];
    assign in_src  = packet_in[31:16];
    assign in_seq  = packet_in[63:32];
    assign in_ack  = packet_in[95:64];
    assign in_fin  = packet_in[112];
    assign in_syn  = packet_in[113];
    assign in_rst  = packet_in[114];
    assign in_psh  = packet_in[115];
    assign in_ackf = packet_in[116];
    assign in_data = packet_in[223:192];

    // Window, URG, pointers, checksum and options are not used by the server
    assign unused_bits = ^{packet_in[191:117], packet_in[111:96]};

    logic        match;
    logic        in_order;
    logic        timed_out;
    logic [31:0] rcv_upd;

    // Before a connection exists any remote port is accepted; afterwards
    // only the latched peer may talk to us.
    assign match = in_valid && (in_dest == LOCAL_PORT) &&
                   ((state == LISTEN) || (in_src == remote_port));

    assign in_order  = (in_seq == rcv_nxt);
    assign timed_out = (timer >= (TIMEOUT - 16'd1));
    assign rcv_upd   = rcv_nxt + (in_psh ? 32'd4 : 32'd0) + (in_fin ? 32'd1 : 32'd0);

    function automatic logic [223:0] build_pkt(
        input logic [15:0] dport,
        input logic [31:0] seq,
        input logic [31:0] ack,
        input logic        syn,
        input logic        ackf,
        input logic        fin
    );
        logic [223:0] p;
        p          = '0;
        p[15:0]    = dport;
        p[31:16]   = LOCAL_PORT;
        p[63:32]   = seq;
        p[95:64]   = ack;
        p[111:96]  = WINDOW;
        p[112]     = fin;
        p[113]     = syn;
        p[116]     = ackf;
        p[127:124] = 4'd5;
        return p;
    endfunction

    always_comb begin
        state_n         = state;
        remote_port_n   = remote_port;
        rcv_nxt_n       = rcv_nxt;
        snd_nxt_n       = snd_nxt;
        out_valid_n     = 1'b0;
        packet_out_n    = packet_out;
        rx_data_n       = rx_data;
        rx_data_valid_n = 1'b0;

        case (state)
            LISTEN: begin
                if (match && in_syn && !in_ackf && !in_rst) begin
                    remote_port_n = in_src;
                    rcv_nxt_n     = in_seq + 32'd1;
                    snd_nxt_n     = ISN + 32'd1;
                    out_valid_n   = 1'b1;
                    // The reply goes to the sender's port directly; remote_port
                    // is only written at this same edge.
                    packet_out_n  = build_pkt(in_src, ISN, in_seq + 32'd1,
                                              1'b1, 1'b1, 1'b0);
                    state_n       = SYN_RCVD;
                end
            end

            SYN_RCVD: begin
                if (match && in_rst) begin
                    state_n = LISTEN;
                end else if (match && in_ackf && (in_ack == snd_nxt)) begin
                    state_n = ESTABLISHED;
                end else if (timed_out) begin
                    state_n = LISTEN;
                end
            end

            ESTABLISHED: begin
                if (match && in_rst) begin
                    state_n = LISTEN;
                end else if (match && (in_psh || in_fin)) begin
                    out_valid_n = 1'b1;
                    if (in_order) begin
                        rcv_nxt_n    = rcv_upd;
                        packet_out_n = build_pkt(remote_port, snd_nxt, rcv_upd,
                                                 1'b0, 1'b1, 1'b0);
                        if (in_psh) begin
                            rx_data_n       = in_data;
                            rx_data_valid_n = 1'b1;
                        end
                        if (in_fin) begin
                            state_n = CLOSE_WAIT;
                        end
                    end else begin
                        // Out-of-order: re-advertise what we still expect
                        packet_out_n = build_pkt(remote_port, snd_nxt, rcv_nxt,
                                                 1'b0, 1'b1, 1'b0);
                    end
                end
            end

            CLOSE_WAIT: begin
                out_valid_n  = 1'b1;
                packet_out_n = build_pkt(remote_port, snd_nxt, rcv_nxt,
                                         1'b0, 1'b1, 1'b1);
                snd_nxt_n    = snd_nxt + 32'd1;
                state_n      = LAST_ACK;
            end

            LAST_ACK: begin
                if (match && in_rst) begin
                    state_n = LISTEN;
                end else if (match && in_ackf && (in_ack == snd_nxt)) begin
                    state_n = LISTEN;
                end else if (timed_out) begin
                    state_n = LISTEN;
                end
            end

            default: state_n = LISTEN;
        endcase

        // Timer restarts on every state change and saturates otherwise
        if (state_n != state) begin
            timer_n = '0;
        end else if (timer == '1) begin
            timer_n = timer;
        end else begin
            timer_n = timer + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LISTEN;
            remote_port   <= '0;
            rcv_nxt       <= '0;
            snd_nxt       <= '0;
            timer         <= '0;
            out_valid     <= 1'b0;
            packet_out    <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            conn_open     <= 1'b0;
        end else begin
            state         <= state_n;
            remote_port   <= remote_port_n;
            rcv_nxt       <= rcv_nxt_n;
            snd_nxt       <= snd_nxt_n;
            timer         <= timer_n;
            out_valid     <= out_valid_n;
            packet_out    <= packet_out_n;
            rx_data       <= rx_data_n;
            rx_data_valid <= rx_data_valid_n;
            conn_open     <= (state_n == ESTABLISHED);
        end
    end

endmodule

// File: tb/tb_tcp_server.sv
module tb_tcp_server;

    localparam int unsigned TMO = 20;

    localparam logic [5:0] F_FIN = 6'b000001;
    localparam logic [5:0] F_SYN = 6'b000010;
    localparam logic [5:0] F_RST = 6'b000100;
    localparam logic [5:0] F_PSH = 6'b001000;
    localparam logic [5:0] F_ACK = 6'b010000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [223:0] packet_in;
    logic         out_valid;
    logic [223:0] packet_out;
    logic [31:0]  rx_data;
    logic         rx_data_valid;
    logic         conn_open;

    always #5 clk = ~clk;

    tcp_server #(
        .LOCAL_PORT(16'd80),
        .ISN(32'h0000_1000),
        .WINDOW(16'd1024),
        .TIMEOUT(16'(TMO))
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .packet_in(packet_in),
        .out_valid(out_valid),
        .packet_out(packet_out),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .conn_open(conn_open)
    );

    typedef struct { int cyc; logic [223:0] pkt; } pexp_t;
    typedef struct { int cyc; logic [31:0]  d;   } dexp_t;
    pexp_t pq[$];
    dexp_t dq[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [223:0] mk_in(input logic [15:0] src, input logic [15:0] dst,
                                           input logic [31:0] seq, input logic [31:0] ack,
                                           input logic [5:0] fl, input logic [31:0] data);
        logic [223:0] p;
        p            = '0;
        p[15:0]      = dst;
        p[31:16]     = src;
        p[63:32]     = seq;
        p[95:64]     = ack;
        p[111:96]    = 16'd512;
        p[117:112]   = fl;
        p[127:124]   = 4'd5;
        p[223:192]   = data;
        return p;
    endfunction

    function automatic logic [223:0] mk_out(input logic [15:0] dst, input logic [31:0] seq,
                                            input logic [31:0] ack, input logic [5:0] fl);
        logic [223:0] p;
        p          = '0;
        p[15:0]    = dst;
        p[31:16]   = 16'd80;
        p[63:32]   = seq;
        p[95:64]   = ack;
        p[111:96]  = 16'd1024;
        p[117:112] = fl;
        p[127:124] = 4'd5;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic exp_pkt(input int dc, input logic [223:0] p);
        pq.push_back('{cyc + dc, p});
    endtask

    task automatic exp_rx(input int dc, input logic [31:0] d);
        dq.push_back('{cyc + dc, d});
    endtask

    // Called at a negedge; the segment is sampled at the following posedge
    task automatic send(input logic [223:0] p);
        in_valid  = 1'b1;
        packet_in = p;
        @(negedge clk);
        in_valid  = 1'b0;
        packet_in = '0;
    endtask

    // Monitor: every DUT output pulse is matched against the scoreboard
    initial begin
        pexp_t pe;
        dexp_t de;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                pe = pq.pop_front();
                checks++; errors++;
                $display("FAIL missing_out cyc=%0d want=%0h", pe.cyc, pe.pkt);
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                de = dq.pop_front();
                checks++; errors++;
                $display("FAIL missing_rx cyc=%0d want=%0h", de.cyc, de.d);
            end
            if (out_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out cyc=%0d got=%0h", cyc, packet_out);
                end else begin
                    pe = pq.pop_front();
                    if (pe.cyc != cyc || pe.pkt !== packet_out) begin
                        errors++;
                        $display("FAIL out_pkt cyc=%0d/%0d got=%0h want=%0h",
                                 cyc, pe.cyc, packet_out, pe.pkt);
                    end
                end
            end
            if (rx_data_valid) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rx cyc=%0d got=%0h", cyc, rx_data);
                end else begin
                    de = dq.pop_front();
                    if (de.cyc != cyc || de.d !== rx_data) begin
                        errors++;
                        $display("FAIL rx_data cyc=%0d/%0d got=%0h want=%0h",
                                 cyc, de.cyc, rx_data, de.d);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        packet_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid",  224'(out_valid), 224'd0);
        chk("rst_packet_out", packet_out, '0);
        chk("rst_rx_data",    224'(rx_data), 224'd0);
        chk("rst_rx_valid",   224'(rx_data_valid), 224'd0);
        chk("rst_conn_open",  224'(conn_open), 224'd0);

        // Wrong port: no response
        send(mk_in(16'd5000, 16'd81, 32'h100, 32'h0, F_SYN, 32'h0));
        repeat (2) @(negedge clk);
        chk("port81_conn_open", 224'(conn_open), 224'd0);

        // Handshake
        exp_pkt(1, mk_out(16'd5000, 32'h1000, 32'h101, F_SYN | F_ACK));
        send(mk_in(16'd5000, 16'd80, 32'h100, 32'h0, F_SYN, 32'h0));
        send(mk_in(16'd5000, 16'd80, 32'h101, 32'h1001, F_ACK, 32'h0));
        chk("hs_conn_open", 224'(conn_open), 224'd1);

        // Data then duplicate (back-to-back)
        exp_pkt(1, mk_out(16'd5000, 32'h1001, 32'h105, F_ACK));
        exp_rx(1, 32'hDEADBEEF);
        send(mk_in(16'd5000, 16'd80, 32'h101, 32'h1001, F_PSH | F_ACK, 32'hDEADBEEF));
        exp_pkt(1, mk_out(16'd5000, 32'h1001, 32'h105, F_ACK));
        send(mk_in(16'd5000, 16'd80, 32'h101, 32'h1001, F_PSH | F_ACK, 32'hDEADBEEF));

        // Passive close
        exp_pkt(1, mk_out(16'd5000, 32'h1001, 32'h106, F_ACK));
        exp_pkt(2, mk_out(16'd5000, 32'h1001, 32'h106, F_FIN | F_ACK));
        send(mk_in(16'd5000, 16'd80, 32'h105, 32'h1001, F_FIN | F_ACK, 32'h0));
        chk("close_wait_conn_open", 224'(conn_open), 224'd0);
        @(negedge clk);
        send(mk_in(16'd5000, 16'd80, 32'h106, 32'h1002, F_ACK, 32'h0));
        repeat (2) @(negedge clk);

        // Sequence wrap (also proves the close returned to LISTEN)
        exp_pkt(1, mk_out(16'd6000, 32'h1000, 32'h0, F_SYN | F_ACK));
        send(mk_in(16'd6000, 16'd80, 32'hFFFF_FFFF, 32'h0, F_SYN, 32'h0));
        send(mk_in(16'd6000, 16'd80, 32'h0, 32'h1001, F_ACK, 32'h0));
        chk("wrap_conn_open", 224'(conn_open), 224'd1);
        exp_pkt(1, mk_out(16'd6000, 32'h1001, 32'h4, F_ACK));
        exp_rx(1, 32'h1234_5678);
        send(mk_in(16'd6000, 16'd80, 32'h0, 32'h1001, F_PSH | F_ACK, 32'h1234_5678));

        // Foreign source port ignored while connected
        send(mk_in(16'd6001, 16'd80, 32'h4, 32'h1001, F_PSH | F_ACK, 32'hAAAA_5555));
        chk("foreign_conn_open", 224'(conn_open), 224'd1);

        // RST beats an in-order PSH
        send(mk_in(16'd6000, 16'd80, 32'h4, 32'h1001, F_RST | F_PSH | F_ACK, 32'hBBBB_0000));
        chk("rst_abort_conn_open", 224'(conn_open), 224'd0);
        repeat (2) @(negedge clk);

        // ACK one cycle before the timeout still completes the handshake
        exp_pkt(1, mk_out(16'd6000, 32'h1000, 32'h201, F_SYN | F_ACK));
        send(mk_in(16'd6000, 16'd80, 32'h200, 32'h0, F_SYN, 32'h0));
        repeat (TMO - 2) @(negedge clk);
        send(mk_in(16'd6000, 16'd80, 32'h201, 32'h1001, F_ACK, 32'h0));
        chk("pre_timeout_conn_open", 224'(conn_open), 224'd1);
        send(mk_in(16'd6000, 16'd80, 32'h201, 32'h1001, F_RST, 32'h0));
        repeat (2) @(negedge clk);

        // No ACK within TIMEOUT cycles: back to LISTEN, late ACK ignored
        exp_pkt(1, mk_out(16'd6000, 32'h1000, 32'h301, F_SYN | F_ACK));
        send(mk_in(16'd6000, 16'd80, 32'h300, 32'h0, F_SYN, 32'h0));
        repeat (TMO) @(negedge clk);
        send(mk_in(16'd6000, 16'd80, 32'h301, 32'h1001, F_ACK, 32'h0));
        chk("timeout_conn_open", 224'(conn_open), 224'd0);
        repeat (2) @(negedge clk);

        // rst while in LAST_ACK
        exp_pkt(1, mk_out(16'd7000, 32'h1000, 32'h401, F_SYN | F_ACK));
        send(mk_in(16'd7000, 16'd80, 32'h400, 32'h0, F_SYN, 32'h0));
        send(mk_in(16'd7000, 16'd80, 32'h401, 32'h1001, F_ACK, 32'h0));
        exp_pkt(1, mk_out(16'd7000, 32'h1001, 32'h402, F_ACK));
        exp_pkt(2, mk_out(16'd7000, 32'h1001, 32'h402, F_FIN | F_ACK));
        send(mk_in(16'd7000, 16'd80, 32'h401, 32'h1001, F_FIN | F_ACK, 32'h0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid",  224'(out_valid), 224'd0);
        chk("mid_rst_packet_out", packet_out, '0);
        chk("mid_rst_rx_data",    224'(rx_data), 224'd0);
        chk("mid_rst_conn_open",  224'(conn_open), 224'd0);
        exp_pkt(1, mk_out(16'd8000, 32'h1000, 32'h501, F_SYN | F_ACK));
        send(mk_in(16'd8000, 16'd80, 32'h500, 32'h0, F_SYN, 32'h0));

        repeat (5) @(negedge clk);
        chk("pending_out", 224'(pq.size()), 224'd0);
        chk("pending_rx",  224'(dq.size()), 224'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
